adc_frontend: RTL and testbench

//  Upstream stage of the fan controller. Captures raw samples from the external ADC, averages
//  2**AVG_LOG2 of them and presents one filtered ADC_BITWIDTH value with a one-cycle valid strobe.

---
 rtl/fanctrl_pkg.sv | 27 ++
 rtl/adc_frontend_sync_edge.sv | 18 +
 rtl/adc_frontend.sv | 182 ++++++++++++++++++
 tb/tb_adc_frontend.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fanctrl_pkg.sv
// Shared fan-controller definitions: FSM state encoding, default ADC width and the
// round-half-up / saturate helper shared with the PID output stage.
package fanctrl_pkg;

  localparam int ADC_BITWIDTH_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    OUT   = ST_OUT
  } state_t;

  // (val + half) >> shift, clamped to an out_bits-wide unsigned maximum.
  function automatic logic [31:0] round_sat(input logic [31:0] val, input int shift,
                                            input int out_bits);
    logic [31:0] r;
    logic [31:0] lim;
    r   = (shift > 0) ? ((val + (32'd1 << (shift - 1))) >> shift) : val;
    lim = (32'd1 << out_bits) - 32'd1;
    return (r > lim) ? lim : r;
  endfunction

endpackage

// File: rtl/adc_frontend_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], async_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/adc_frontend.sv
// ADC front end: captures raw samples, averages 2**AVG_LOG2 of them with rounding and
// saturation, strobes the result and flags a stalled ADC. `define ADC_MEDIAN3_EN adds a 3-tap median.
module adc_frontend
  import fanctrl_pkg::*;
#(
  parameter int ADC_BITWIDTH = ADC_BITWIDTH_DEF,
  parameter int AVG_LOG2     = 2,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_i,
  input  logic [ADC_BITWIDTH-1:0] adc_raw_i,
  input  logic                    adc_ready_i,
  input  logic                    flush_i,
  output logic [ADC_BITWIDTH-1:0] ADC_value_o,
  output logic                    dataVaild_STRB_o,
  output logic                    adc_timeout_o,
  output logic [1:0]              state_o
);

  localparam int AW = ADC_BITWIDTH + AVG_LOG2 + 1;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] NSAMP = CW'(1 << AVG_LOG2);

  state_t                  state, state_nx;
  logic [AW-1:0]           acc, acc_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [TW-1:0]           tmo, tmo_nx;
  logic                    pend, pend_nx;
  logic [ADC_BITWIDTH-1:0] pdata, pdata_nx;
  logic                    tflag, tflag_nx;
  logic [ADC_BITWIDTH-1:0] value, value_nx;
  logic                    strb, strb_nx;
  logic                    rise;
  logic                    take;
  logic                    restart;
  logic [ADC_BITWIDTH-1:0] sample;

  sync_edge u_ready_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .async_i(adc_ready_i),
    .rise_o (rise)
  );

`ifdef ADC_MEDIAN3_EN
  logic [ADC_BITWIDTH-1:0] win0, win1;
  logic                    win_vld;

  function automatic logic [ADC_BITWIDTH-1:0] med3(input logic [ADC_BITWIDTH-1:0] a,
                                                   input logic [ADC_BITWIDTH-1:0] b,
                                                   input logic [ADC_BITWIDTH-1:0] c);
    if (a > b) return (b > c) ? b : ((a > c) ? c : a);
    else       return (a > c) ? a : ((b > c) ? c : b);
  endfunction

  // First sample of a fresh window acts as its own median (window preloaded with it).
  assign sample = win_vld ? med3(pdata, win0, win1) : pdata;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      win0    <= '0;
      win1    <= '0;
      win_vld <= 1'b0;
    end else if (restart) begin
      win_vld <= 1'b0;
    end else if (take) begin
      win_vld <= 1'b1;
      win0    <= pdata;
      win1    <= win_vld ? win0 : pdata;
    end
  end
`else
  assign sample = pdata;
`endif

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    tmo_nx   = tmo;
    pend_nx  = pend;
    pdata_nx = pdata;
    tflag_nx = tflag;
    value_nx = value;
    strb_nx  = 1'b0;
    take     = 1'b0;
    restart  = 1'b0;

    if (clk_en_i) begin
      unique case (state)
        IDLE: begin
          if (pend) begin
            take     = 1'b1;
            acc_nx   = AW'(sample);
            cnt_nx   = CW'(1);
            tmo_nx   = '0;
            state_nx = (AVG_LOG2 == 0) ? OUT : ACCUM;
          end
        end
        ACCUM: begin
          if (pend) begin
            take   = 1'b1;
            acc_nx = acc + AW'(sample);
            cnt_nx = cnt + 1'b1;
            tmo_nx = '0;
            if (cnt + 1'b1 == NSAMP) state_nx = OUT;
          end else if (32'(tmo) + 32'd1 >= 32'(TIMEOUT_CYC)) begin
            tflag_nx = 1'b1;
            acc_nx   = '0;
            cnt_nx   = '0;
            tmo_nx   = '0;
            restart  = 1'b1;
            state_nx = IDLE;
          end else begin
            tmo_nx = tmo + 1'b1;
          end
        end
        OUT: begin
          value_nx = ADC_BITWIDTH'(round_sat(32'(acc), AVG_LOG2, ADC_BITWIDTH));
          strb_nx  = 1'b1;
          acc_nx   = '0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end

    // A new edge after consumption re-arms pending; before consumption it overwrites (newest wins).
    if (take) pend_nx = 1'b0;
    if (rise) begin
      pend_nx  = 1'b1;
      pdata_nx = adc_raw_i;
    end

    if (flush_i) begin
      acc_nx   = '0;
      cnt_nx   = '0;
      tmo_nx   = '0;
      pend_nx  = 1'b0;
      tflag_nx = 1'b0;
      value_nx = value;
      strb_nx  = 1'b0;
      state_nx = IDLE;
      take     = 1'b0;
      restart  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      tmo   <= '0;
      pend  <= 1'b0;
      pdata <= '0;
      tflag <= 1'b0;
      value <= '0;
      strb  <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      tmo   <= tmo_nx;
      pend  <= pend_nx;
      pdata <= pdata_nx;
      tflag <= tflag_nx;
      value <= value_nx;
      strb  <= strb_nx;
    end
  end

  assign ADC_value_o      = value;
  assign dataVaild_STRB_o = strb;
  assign adc_timeout_o    = tflag;
  assign state_o          = state;

endmodule

// File: tb/tb_adc_frontend.sv
// Self-checking bench for adc_frontend: randomized async ready pulses, averaging reference
// model feeding a scoreboard queue, separate strobe monitor.
module tb_adc_frontend;

  localparam int W   = 4;
  localparam int L   = 2;
  localparam int N   = 1 << L;
  localparam int TMO = 64;
  localparam int MAXV = (1 << W) - 1;

  logic         clk    = 1'b0;
  logic         rstn   = 1'b0;
  logic         clk_en = 1'b0;
  logic         ready  = 1'b0;
  logic         flush  = 1'b0;
  logic [W-1:0] raw    = '0;
  logic [W-1:0] value;
  logic         strb;
  logic         tmo_flag;
  logic [1:0]   state;

  adc_frontend #(.ADC_BITWIDTH(W), .AVG_LOG2(L), .TIMEOUT_CYC(TMO)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .clk_en_i        (clk_en),
    .adc_raw_i       (raw),
    .adc_ready_i     (ready),
    .flush_i         (flush),
    .ADC_value_o     (value),
    .dataVaild_STRB_o(strb),
    .adc_timeout_o   (tmo_flag),
    .state_o         (state)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int div     = 1;
  int strobes = 0;
  int n_exp   = 0;
  int exp_q[$];
  int win[$];
  int hist[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int med3(input int a, input int b, input int c);
    int s[$];
    s = {a, b, c};
    s.sort();
    return s[1];
  endfunction

  // Reference: collect N (optionally median-filtered) samples, emit rounded saturated mean.
  task automatic model_sample(input int v);
    int e;
    int sum;
    e = v;
`ifdef ADC_MEDIAN3_EN
    if (hist.size() == 0) hist = {v, v, v};
    else begin
      hist.push_front(v);
      void'(hist.pop_back());
    end
    e = med3(hist[0], hist[1], hist[2]);
`endif
    win.push_back(e);
    if (win.size() == N) begin
      sum = 0;
      foreach (win[i]) sum += win[i];
      sum = (sum + N / 2) / N;
      if (sum > MAXV) sum = MAXV;
      exp_q.push_back(sum);
      n_exp++;
      win.delete();
    end
  endtask

  task automatic model_clear();
    win.delete();
    hist.delete();
  endtask

  // Ready pulse at a random phase relative to clk; spacing lets each capture be consumed.
  task automatic send(input int v);
    #($urandom_range(1, 9));
    raw = W'(v);
    #($urandom_range(1, 4));
    ready = 1'b1;
    model_sample(v);
    #((3 + $urandom_range(0, 2)) * 10);
    ready = 1'b0;
    #(((div == 1) ? 5 : 3 * div + 2) * 10 + $urandom_range(0, 9));
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("strobe_wait_timeout", exp_q.size(), 0);
    repeat (3 * div + 3) @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    int dc;
    dc = 0;
    forever begin
      @(posedge clk);
      #1;
      dc = (dc + 1 >= div) ? 0 : dc + 1;
      clk_en = (dc == 0);
    end
  end

  // Monitor: every strobe must be single-cycle, expected, and leave the FSM idle.
  initial begin
    logic strb_d;
    strb_d = 1'b0;
    forever begin
      @(negedge clk);
      if (strb) begin
        strobes++;
        chk("strobe_width", int'(strb_d), 0);
        chk("state_at_strobe", int'(state), 0);
        if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else chk("value", int'(value), exp_q.pop_front());
      end
      strb_d = strb;
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_value", int'(value), 0);
    chk("rst_strobe", int'(strb), 0);
    chk("rst_timeout", int'(tmo_flag), 0);
    chk("rst_state", int'(state), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // basic average and rounding
    send(3); send(4); send(4); send(5);
    wait_done(500);
    chk("t1_value", int'(value), 4);
    chk("t1_state", int'(state), 0);

    // saturation path
    send(15); send(15); send(15); send(14);
    wait_done(500);
    chk("t2a_value", int'(value), 15);
    repeat (4) send(15);
    wait_done(500);
    chk("t2b_value", int'(value), 15);

    // stall mid-average -> sticky timeout, partial window dropped
    send(8); send(8);
    repeat (TMO + 10) @(negedge clk);
    model_clear();
    chk("t3_timeout_set", int'(tmo_flag), 1);
    chk("t3_state_idle", int'(state), 0);
    repeat (4) send(8);
    wait_done(500);
    chk("t3_value", int'(value), 8);
    chk("t3_timeout_sticky", int'(tmo_flag), 1);
    do_flush();
    chk("t3_timeout_cleared", int'(tmo_flag), 0);

    // flush mid-window: no strobe, old value held
    send(9); send(9); send(9);
    repeat (5) @(negedge clk);
    do_flush();
    chk("t4_held_after_flush", int'(value), 8);
    chk("t4_state_idle", int'(state), 0);
    send(2); send(2); send(2);
    repeat (3) @(negedge clk);
    chk("t4_held_partial", int'(value), 8);
    send(2);
    wait_done(500);
    chk("t4_value", int'(value), 2);

    // single-sample spike
    do_flush();
    send(4); send(4); send(15); send(4);
    wait_done(500);
`ifdef ADC_MEDIAN3_EN
    chk("t6_spike", int'(value), 4);
`else
    chk("t6_spike", int'(value), 7);
`endif

    // slow timebase, random data
    div = 10;
    begin
      int s0;
      s0 = strobes;
      for (int k = 0; k < 3 * N; k++) send(int'($urandom_range(0, MAXV)));
      wait_done(5000);
      chk("t5_strobe_count", strobes - s0, 3);
    end
    div = 1;
    repeat (12) @(negedge clk);

    // async reset mid-average
    send(12); send(13);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    model_clear();
    #3;
    chk("rst2_value", int'(value), 0);
    chk("rst2_state", int'(state), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // random windows including extremes
    for (int k = 0; k < 6 * N; k++) begin
      case ($urandom_range(0, 3))
        0:       send(0);
        1:       send(MAXV);
        default: send(int'($urandom_range(0, MAXV)));
      endcase
    end
    wait_done(1000);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("total_strobes", strobes, n_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
